// File: rtl/video_timing_gen.sv
// Raster timing generator for the DVI/TMDS encoder: sync/DE generation, one-cycle FIFO
// read requests with pixel coordinates, and a per-frame selectable colour-bar source.
module video_timing_gen #(
    parameter int H_SYNC  = 40,
    parameter int H_BACK  = 220,
    parameter int H_DISP  = 1280,
    parameter int H_FRONT = 110,
    parameter int V_SYNC  = 5,
    parameter int V_BACK  = 20,
    parameter int V_DISP  = 720,
    parameter int V_FRONT = 5,
    parameter int HS_POL  = 1,
    parameter int VS_POL  = 1
) (
    input  logic        pixelclk,
    input  logic        rst_n,
    input  logic        pattern_en,
    input  logic [23:0] pixel_data,
    output logic        data_req,
    output logic [11:0] pixel_x,
    output logic [11:0] pixel_y,
    output logic        frame_start,
    output logic        video_hs,
    output logic        video_vs,
    output logic        video_de,
    output logic [7:0]  video_r,
    output logic [7:0]  video_g,
    output logic [7:0]  video_b
);

    localparam logic [11:0] H_TOTAL = 12'(H_SYNC + H_BACK + H_DISP + H_FRONT);
    localparam logic [11:0] V_TOTAL = 12'(V_SYNC + V_BACK + V_DISP + V_FRONT);
    localparam logic [11:0] H_LAST  = H_TOTAL - 12'd1;
    localparam logic [11:0] V_LAST  = V_TOTAL - 12'd1;
    localparam logic [11:0] H_SW    = 12'(H_SYNC);
    localparam logic [11:0] V_SW    = 12'(V_SYNC);
    localparam logic [11:0] H_ACT_S = 12'(H_SYNC + H_BACK);
    localparam logic [11:0] H_ACT_E = 12'(H_SYNC + H_BACK + H_DISP);
    localparam logic [11:0] V_ACT_S = 12'(V_SYNC + V_BACK);
    localparam logic [11:0] V_ACT_E = 12'(V_SYNC + V_BACK + V_DISP);
    localparam int          BAR_W_I = ((H_DISP / 8) > 0) ? (H_DISP / 8) : 1;
    localparam logic [11:0] BAR_W   = 12'(BAR_W_I);
    localparam logic        HS_ON   = 1'(HS_POL);
    localparam logic        VS_ON   = 1'(VS_POL);

    function automatic logic [2:0] bar_index(input logic [11:0] x);
        logic [11:0] q;
        q = x / BAR_W;
        return (q > 12'd7) ? 3'd7 : q[2:0];
    endfunction

    function automatic logic [23:0] bar_colour(input logic [2:0] idx);
        logic [23:0] c;
        case (idx)
            3'd0:    c = 24'hFFFFFF;
            3'd1:    c = 24'hFFFF00;
            3'd2:    c = 24'h00FFFF;
            3'd3:    c = 24'h00FF00;
            3'd4:    c = 24'hFF00FF;
            3'd5:    c = 24'hFF0000;
            3'd6:    c = 24'h0000FF;
            3'd7:    c = 24'h000000;
            default: c = 24'h000000;
        endcase
        return c;
    endfunction

    logic [11:0] h_cnt_q, h_cnt_d;
    logic [11:0] v_cnt_q, v_cnt_d;
    logic        pattern_q, pattern_d;
    logic        data_req_q, data_req_d;
    logic [11:0] pixel_x_q, pixel_x_d;
    logic [11:0] pixel_y_q, pixel_y_d;
    logic        frame_start_q, frame_start_d;
    logic        s1_de_q, s1_de_d;
    logic        s1_hs_q, s1_hs_d;
    logic        s1_vs_q, s1_vs_d;
    logic        s1_pat_q, s1_pat_d;
    logic [11:0] s1_x_q, s1_x_d;
    logic        s2_de_q, s2_de_d;
    logic        s2_hs_q, s2_hs_d;
    logic        s2_vs_q, s2_vs_d;
    logic        s2_pat_q, s2_pat_d;
    logic [23:0] s2_bar_q, s2_bar_d;
    logic        video_de_q, video_de_d;
    logic        video_hs_q, video_hs_d;
    logic        video_vs_q, video_vs_d;
    logic [23:0] video_rgb_q, video_rgb_d;
    logic        frame_pos_s;
    logic        h_wrap_s;
    logic        active_s;

    // Counters, pattern latch and the three pipeline stages.
    always_comb begin
        frame_pos_s = (h_cnt_q == 12'd0) && (v_cnt_q == 12'd0);
        h_wrap_s    = (h_cnt_q == H_LAST);
        active_s    = (h_cnt_q >= H_ACT_S) && (h_cnt_q < H_ACT_E) &&
                      (v_cnt_q >= V_ACT_S) && (v_cnt_q < V_ACT_E);

        h_cnt_d = h_wrap_s ? 12'd0 : (h_cnt_q + 12'd1);
        v_cnt_d = v_cnt_q;
        if (h_wrap_s) begin
            v_cnt_d = (v_cnt_q == V_LAST) ? 12'd0 : (v_cnt_q + 12'd1);
        end else begin
            v_cnt_d = v_cnt_q;
        end

        // The pattern choice only changes at the frame origin, which is never active.
        pattern_d     = frame_pos_s ? pattern_en : pattern_q;
        frame_start_d = frame_pos_s;

        s1_de_d  = active_s;
        s1_hs_d  = (h_cnt_q < H_SW) ? HS_ON : ~HS_ON;
        s1_vs_d  = (v_cnt_q < V_SW) ? VS_ON : ~VS_ON;
        s1_pat_d = pattern_q;
        s1_x_d   = active_s ? (h_cnt_q - H_ACT_S) : 12'd0;

        data_req_d = active_s && !pattern_q;
        pixel_x_d  = data_req_d ? (h_cnt_q - H_ACT_S) : 12'd0;
        pixel_y_d  = data_req_d ? (v_cnt_q - V_ACT_S) : 12'd0;

        s2_de_d  = s1_de_q;
        s2_hs_d  = s1_hs_q;
        s2_vs_d  = s1_vs_q;
        s2_pat_d = s1_pat_q;
        s2_bar_d = bar_colour(bar_index(s1_x_q));

        video_de_d  = s2_de_q;
        video_hs_d  = s2_hs_q;
        video_vs_d  = s2_vs_q;
        video_rgb_d = s2_de_q ? (s2_pat_q ? s2_bar_q : pixel_data) : 24'h000000;
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge pixelclk) begin
        if (!rst_n) begin
            h_cnt_q       <= 12'd0;
            v_cnt_q       <= 12'd0;
            pattern_q     <= 1'b0;
            frame_start_q <= 1'b0;
            data_req_q    <= 1'b0;
            pixel_x_q     <= 12'd0;
            pixel_y_q     <= 12'd0;
            s1_de_q       <= 1'b0;
            s1_hs_q       <= ~HS_ON;
            s1_vs_q       <= ~VS_ON;
            s1_pat_q      <= 1'b0;
            s1_x_q        <= 12'd0;
            s2_de_q       <= 1'b0;
            s2_hs_q       <= ~HS_ON;
            s2_vs_q       <= ~VS_ON;
            s2_pat_q      <= 1'b0;
            s2_bar_q      <= 24'h000000;
            video_de_q    <= 1'b0;
            video_hs_q    <= ~HS_ON;
            video_vs_q    <= ~VS_ON;
            video_rgb_q   <= 24'h000000;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            pattern_q     <= pattern_d;
            frame_start_q <= frame_start_d;
            data_req_q    <= data_req_d;
            pixel_x_q     <= pixel_x_d;
            pixel_y_q     <= pixel_y_d;
            s1_de_q       <= s1_de_d;
            s1_hs_q       <= s1_hs_d;
            s1_vs_q       <= s1_vs_d;
            s1_pat_q      <= s1_pat_d;
            s1_x_q        <= s1_x_d;
            s2_de_q       <= s2_de_d;
            s2_hs_q       <= s2_hs_d;
            s2_vs_q       <= s2_vs_d;
            s2_pat_q      <= s2_pat_d;
            s2_bar_q      <= s2_bar_d;
            video_de_q    <= video_de_d;
            video_hs_q    <= video_hs_d;
            video_vs_q    <= video_vs_d;
            video_rgb_q   <= video_rgb_d;
        end
    end

    assign data_req    = data_req_q;
    assign pixel_x     = pixel_x_q;
    assign pixel_y     = pixel_y_q;
    assign frame_start = frame_start_q;
    assign video_hs    = video_hs_q;
    assign video_vs    = video_vs_q;
    assign video_de    = video_de_q;
    assign video_r     = video_rgb_q[23:16];
    assign video_g     = video_rgb_q[15:8];
    assign video_b     = video_rgb_q[7:0];

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen on a reduced raster: spot-check table plus a time-indexed
// reference model driven by random pattern selection, frame counts and a mid-frame reset.
module tb_video_timing_gen;

    localparam int HS = 4,  HB = 6,  HD = 16, HF = 3;
    localparam int VS = 2,  VB = 3,  VD = 6,  VF = 2;
    localparam int HT = HS + HB + HD + HF;
    localparam int VT = VS + VB + VD + VF;
    localparam int FT = HT * VT;
    localparam int HA = HS + HB;
    localparam int VA = VS + VB;
    localparam bit HS_POL = 1'b1;
    localparam bit VS_POL = 1'b0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pattern_en;
    logic [23:0] pixel_data;
    logic        data_req;
    logic [11:0] pixel_x, pixel_y;
    logic        frame_start, video_hs, video_vs, video_de;
    logic [7:0]  video_r, video_g, video_b;

    always #5 clk = ~clk;

    video_timing_gen #(
        .H_SYNC(HS), .H_BACK(HB), .H_DISP(HD), .H_FRONT(HF),
        .V_SYNC(VS), .V_BACK(VB), .V_DISP(VD), .V_FRONT(VF),
        .HS_POL(1), .VS_POL(0)
    ) dut (
        .pixelclk(clk), .rst_n(rst_n), .pattern_en(pattern_en), .pixel_data(pixel_data),
        .data_req(data_req), .pixel_x(pixel_x), .pixel_y(pixel_y), .frame_start(frame_start),
        .video_hs(video_hs), .video_vs(video_vs), .video_de(video_de),
        .video_r(video_r), .video_g(video_g), .video_b(video_b)
    );

    int checks = 0;
    int errors = 0;
    int k = 0;
    bit pat_of_frame [int];
    logic [23:0] bars [8];

    typedef struct {
        int          k;
        logic        req;
        logic [11:0] x;
        logic [11:0] y;
        logic        fs;
        logic        de;
        logic        hs;
        logic        vs;
        logic [23:0] rgb;
    } vec_t;
    vec_t vecs [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s k=%0d actual=%h required=%h", name, k, act, exp);
        end
    endtask

    function automatic int hpos(input int p); return p % HT; endfunction
    function automatic int vpos(input int p); return (p / HT) % VT; endfunction
    function automatic bit in_act(input int p);
        return hpos(p) >= HA && hpos(p) < HA + HD && vpos(p) >= VA && vpos(p) < VA + VD;
    endfunction
    function automatic bit pat_at(input int p);
        return pat_of_frame.exists(p / FT) ? pat_of_frame[p / FT] : 1'b0;
    endfunction

    // Expected outputs after k non-reset edges: request stage shows position k-1, video k-3.
    task automatic model_check();
        int          pd, pv, bi;
        logic        e_req, e_fs, e_de, e_hs, e_vs;
        logic [11:0] e_x, e_y;
        logic [23:0] e_rgb;
        pd    = k - 1;
        pv    = k - 3;
        e_req = (k >= 1) && in_act(pd) && !pat_at(pd);
        e_x   = e_req ? 12'(hpos(pd) - HA) : 12'd0;
        e_y   = e_req ? 12'(vpos(pd) - VA) : 12'd0;
        e_fs  = (k >= 1) && (pd % FT == 0);
        e_hs  = (k >= 3) ? ((hpos(pv) < HS) ? HS_POL : !HS_POL) : !HS_POL;
        e_vs  = (k >= 3) ? ((vpos(pv) < VS) ? VS_POL : !VS_POL) : !VS_POL;
        e_de  = (k >= 3) && in_act(pv);
        e_rgb = 24'h000000;
        if (e_de) begin
            bi = (hpos(pv) - HA) / (HD / 8);
            if (bi > 7) bi = 7;
            e_rgb = pat_at(pv) ? bars[bi]
                               : {8'(vpos(pv) - VA), 8'(hpos(pv) - HA), 8'hA5};
        end
        chk("data_req", 32'(data_req), 32'(e_req));
        chk("pixel_x", 32'(pixel_x), 32'(e_x));
        chk("pixel_y", 32'(pixel_y), 32'(e_y));
        chk("frame_start", 32'(frame_start), 32'(e_fs));
        chk("video_hs", 32'(video_hs), 32'(e_hs));
        chk("video_vs", 32'(video_vs), 32'(e_vs));
        chk("video_de", 32'(video_de), 32'(e_de));
        chk("video_rgb", 32'({video_r, video_g, video_b}), 32'(e_rgb));
    endtask

    // One clock: apply inputs, act as the one-cycle-latency FIFO, then check at negedge.
    task automatic tick(input logic r, input logic p);
        logic        pr;
        logic [11:0] px, py;
        rst_n      = r;
        pattern_en = p;
        pr = data_req;
        px = pixel_x;
        py = pixel_y;
        @(posedge clk);
        if (!r) begin
            k = 0;
            pat_of_frame.delete();
        end else begin
            if (k % FT == 0) pat_of_frame[k / FT] = p;
            k++;
        end
        #1;
        pixel_data = pr ? {py[7:0], px[7:0], 8'hA5} : 24'($urandom);
        @(negedge clk);
        model_check();
    endtask

    initial begin
        int n_req, n_hs, n_vsl;
        bars[0] = 24'hFFFFFF; bars[1] = 24'hFFFF00; bars[2] = 24'h00FFFF; bars[3] = 24'h00FF00;
        bars[4] = 24'hFF00FF; bars[5] = 24'hFF0000; bars[6] = 24'h0000FF; bars[7] = 24'h000000;

        vecs[0]  = '{0,   1'b0, 12'd0,  12'd0, 1'b0, 1'b0, 1'b0, 1'b1, 24'h000000};
        vecs[1]  = '{1,   1'b0, 12'd0,  12'd0, 1'b1, 1'b0, 1'b0, 1'b1, 24'h000000};
        vecs[2]  = '{2,   1'b0, 12'd0,  12'd0, 1'b0, 1'b0, 1'b0, 1'b1, 24'h000000};
        vecs[3]  = '{3,   1'b0, 12'd0,  12'd0, 1'b0, 1'b0, 1'b1, 1'b0, 24'h000000};
        vecs[4]  = '{7,   1'b0, 12'd0,  12'd0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h000000};
        vecs[5]  = '{60,  1'b0, 12'd0,  12'd0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h000000};
        vecs[6]  = '{61,  1'b0, 12'd0,  12'd0, 1'b0, 1'b0, 1'b1, 1'b1, 24'h000000};
        vecs[7]  = '{156, 1'b1, 12'd0,  12'd0, 1'b0, 1'b0, 1'b0, 1'b1, 24'h000000};
        vecs[8]  = '{157, 1'b1, 12'd1,  12'd0, 1'b0, 1'b0, 1'b0, 1'b1, 24'h000000};
        vecs[9]  = '{158, 1'b1, 12'd2,  12'd0, 1'b0, 1'b1, 1'b0, 1'b1, 24'h0000A5};
        vecs[10] = '{316, 1'b1, 12'd15, 12'd5, 1'b0, 1'b1, 1'b0, 1'b1, 24'h050DA5};
        vecs[11] = '{317, 1'b0, 12'd0,  12'd0, 1'b0, 1'b1, 1'b0, 1'b1, 24'h050EA5};
        vecs[12] = '{318, 1'b0, 12'd0,  12'd0, 1'b0, 1'b1, 1'b0, 1'b1, 24'h050FA5};
        vecs[13] = '{319, 1'b0, 12'd0,  12'd0, 1'b0, 1'b0, 1'b0, 1'b1, 24'h000000};
        vecs[14] = '{377, 1'b0, 12'd0,  12'd0, 1'b0, 1'b0, 1'b0, 1'b1, 24'h000000};
        vecs[15] = '{378, 1'b0, 12'd0,  12'd0, 1'b1, 1'b0, 1'b0, 1'b1, 24'h000000};

        rst_n = 1'b0;
        pattern_en = 1'b0;
        pixel_data = 24'h000000;
        @(negedge clk);
        repeat (3) tick(1'b0, 1'b0);

        for (int i = 0; i < 16; i++) begin
            while (k < vecs[i].k) tick(1'b1, 1'b0);
            chk("vec_req", 32'(data_req), 32'(vecs[i].req));
            chk("vec_x", 32'(pixel_x), 32'(vecs[i].x));
            chk("vec_y", 32'(pixel_y), 32'(vecs[i].y));
            chk("vec_fs", 32'(frame_start), 32'(vecs[i].fs));
            chk("vec_de", 32'(video_de), 32'(vecs[i].de));
            chk("vec_hs", 32'(video_hs), 32'(vecs[i].hs));
            chk("vec_vs", 32'(video_vs), 32'(vecs[i].vs));
            chk("vec_rgb", 32'({video_r, video_g, video_b}), 32'(vecs[i].rgb));
        end

        // Random pattern_en every cycle: mid-frame toggles must not change the source.
        for (int i = 0; i < 3 * FT; i++) tick(1'b1, 1'(($urandom) & 32'd1));

        // A forced colour-bar frame must issue no FIFO reads.
        while (k % FT != 0) tick(1'b1, 1'b0);
        n_req = 0;
        for (int i = 0; i < FT; i++) begin
            tick(1'b1, 1'b1);
            if (data_req) n_req++;
        end
        chk("pattern_frame_req_count", 32'(n_req), 32'd0);

        // A normal frame: request count and sync duty cycles.
        n_req = 0; n_hs = 0; n_vsl = 0;
        for (int i = 0; i < FT; i++) begin
            tick(1'b1, 1'b0);
            if (data_req) n_req++;
            if (video_hs) n_hs++;
            if (!video_vs) n_vsl++;
        end
        chk("frame_req_count", 32'(n_req), 32'(HD * VD));
        chk("frame_hs_count", 32'(n_hs), 32'(HS * VT));
        chk("frame_vs_count", 32'(n_vsl), 32'(VS * HT));

        // Reset for 3 cycles in the middle of an active line.
        while (k % FT != 7 * HT + 12) tick(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b1);
            chk("rst_req", 32'(data_req), 32'd0);
            chk("rst_de", 32'(video_de), 32'd0);
            chk("rst_hs", 32'(video_hs), 32'(!HS_POL));
            chk("rst_vs", 32'(video_vs), 32'(!VS_POL));
        end
        tick(1'b1, 1'b0);
        chk("post_rst_frame_start", 32'(frame_start), 32'd1);
        for (int i = 0; i < FT + 40; i++) tick(1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Generates the raster timing and pixel stream that feed the DVI/TMDS encoder (hsync, vsync, de and 8-bit R/G/B) in the pixelclk domain.
- Pulls pixels from the upstream SDRAM read FIFO with a one-cycle-latency read request and aligns them with the timing signals.
- Supplies pixel coordinates and a frame-start pulse.
- Has a built-in colour-bar pattern for bring-up without SDRAM.

Parameters:
H_SYNC, 40, hsync width in pixel clocks
H_BACK, 220, horizontal back porch
H_DISP, 1280, active pixels per line
H_FRONT, 110, horizontal front porch
V_SYNC, 5, vsync width in lines
V_BACK, 20, vertical back porch
V_DISP, 720, active lines
V_FRONT, 5, vertical front porch
HS_POL, 1, hsync active level
VS_POL, 1, vsync active level

Ports:
pixelclk  in  1  pixel clock (74.25 MHz at default parameters)
rst_n  in  1  synchronous active-low reset, sampled on rising pixelclk
pattern_en  in  1  1 = output internal colour bars instead of pixel_data
pixel_data  in  24  {R,G,B} from read FIFO, valid the cycle after data_req
data_req  out  1  FIFO read request, one per active pixel
pixel_x  out  12  active column of the pixel being requested
pixel_y  out  12  active row of the pixel being requested
frame_start  out  1  one-cycle pulse at start of each frame
video_hs  out  1  horizontal sync to encoder
video_vs  out  1  vertical sync to encoder
video_de  out  1  data enable to encoder
video_r  out  8  red
video_g  out  8  green
video_b  out  8  blue

Behaviour:
- Derived constants: H_TOTAL = sum of H_*; V_TOTAL = sum of V_*. Defaults give 1650 x 750.
- h_cnt counts 0..H_TOTAL-1, wrapping to 0.
- v_cnt increments when h_cnt wraps, and itself wraps to 0 after V_TOTAL-1.
- Sync windows:
  - Horizontal sync active for h_cnt < H_SYNC.
  - Vertical sync active for v_cnt < V_SYNC.
  - A sync output equals its *_POL level when active and the inverse otherwise.
- Active window: H_SYNC+H_BACK <= h_cnt < H_SYNC+H_BACK+H_DISP AND V_SYNC+V_BACK <= v_cnt < V_SYNC+V_BACK+V_DISP.
- data_req:
  - Registered; high exactly during cycles whose counter state lies in the active window.
  - Exactly H_DISP consecutive cycles per active line; never asserted outside the window.
- pixel_x / pixel_y:
  - Registered alongside data_req, equal to h_cnt-(H_SYNC+H_BACK) and v_cnt-(V_SYNC+V_BACK).
  - Held at 0 when data_req is low.
- Pipeline alignment:
  - video_hs, video_vs and video_de are the data_req-stage timing signals delayed 2 further cycles, so video_de rises 2 cycles after data_req.
  - pixel_data is registered in the cycle after data_req, giving video_rgb aligned with video_de.
- video_r/g/b:
  - Forced to 0 whenever video_de is 0.
  - Otherwise equal to pixel_data, or to the colour bar when the pattern is active.
- Colour bars:
  - Bar index = pixel_x / (H_DISP/8), saturating at 7.
  - Colours for bars 0..7: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
  - The bar colour is pipelined with the same latency as pixel_data.
- pattern_en is sampled only when h_cnt==0 and v_cnt==0. No mid-frame switch; the sampled value applies to the whole frame.
- frame_start:
  - Registered one-cycle pulse in the cycle following the counter state h_cnt==0, v_cnt==0.
  - Its effect on the FIFO path: data_req stays 0 while pattern is active, so the FIFO is not drained.
- Reset (rst_n=0 at a rising edge):
  - h_cnt, v_cnt, the pattern latch and all pipeline registers clear.
  - data_req=0, pixel_x=0, pixel_y=0, frame_start=0, video_de=0, video_r/g/b=0.
  - video_hs=~HS_POL and video_vs=~VS_POL.
- Reset asserted mid-frame aborts the frame immediately.
- After release, counting restarts at h_cnt=0, v_cnt=0, and the first frame_start appears 1 cycle after the first non-reset edge.
- Counter widths: 12 bits, sufficient up to 4095 total; parameter sums beyond 4095 are unsupported.

Test Plan:
1. Reset then run 2 frames at defaults:
   - frame_start period is 1,237,500 cycles.
   - video_hs is high for 40 of every 1650 cycles.
   - video_vs is high for 5x1650 cycles per frame.
2. Count data_req per frame:
   - Exactly 921,600 pulses, 1280 contiguous per line.
   - The first pulse of each line has pixel_x=0; the first line of the frame has pixel_y=0.
   - The last pulse has pixel_x=1279, pixel_y=719.
3. Drive pixel_data = {pixel_y[7:0], pixel_x[7:0], 8'hA5} delayed one cycle after data_req:
   - Every video_de=1 cycle shows the matching coordinates.
   - video_de rises exactly 2 cycles after data_req.
   - RGB is 0 when video_de=0.
4. pattern_en=1 before frame start:
   - pixel_x 0..159 gives FFFFFF; 160..319 gives FFFF00; 1120..1279 gives 000000.
   - data_req stays 0 for the whole frame.
5. Toggle pattern_en mid-frame: the output source is unchanged until the next frame_start, then switches.
6. Assert rst_n=0 for 3 cycles at v_cnt=300:
   - All outputs go to reset values at the next edge.
   - After release, frame_start fires after 1 cycle and timing restarts from line 0.
